// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack engine with an opcode command port.
// One opcode per apply cycle; top of stack is always visible on head.
// Optional feature macro: PARAM_STACK_ALU_EN enables the two-operand ALU
// opcodes 6-10 (ADD, SUB, AND, OR, XOR). Without it those opcodes are
// rejected like the reserved ones and no ALU logic is built.
module param_stack #(
    parameter int W  = 8,
    parameter int D  = 8,
    parameter int SW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in,
    input  logic [3:0]    op,
    input  logic          apply,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [SW-1:0] size,
    output logic          valid
);

    localparam int AW = $clog2(D);
    localparam logic [SW-1:0] D_SZ = SW'(D);
    localparam logic [SW-1:0] ONE  = SW'(1);
    localparam logic [SW-1:0] TWO  = SW'(2);

    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_DUP   = 4'd2;
    localparam logic [3:0] OP_SWAP  = 4'd3;
    localparam logic [3:0] OP_OVER  = 4'd4;
    localparam logic [3:0] OP_CLEAR = 4'd5;
`ifdef PARAM_STACK_ALU_EN
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
`endif

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [SW-1:0] size_q, size_d;
    logic          valid_q, valid_d;

    logic [AW-1:0] t_idx, s_idx, p_idx;
    logic [W-1:0]  t_val, s_val;
    logic          is_empty, is_full, has_two;

    // Entry pointers and status decoded from the occupancy counter.
    // Out-of-range pointer values are only used when the op is rejected.
    always_comb begin
        t_idx    = AW'(size_q - ONE);
        s_idx    = AW'(size_q - TWO);
        p_idx    = AW'(size_q);
        t_val    = mem_q[t_idx];
        s_val    = mem_q[s_idx];
        is_empty = (size_q == '0);
        is_full  = (size_q == D_SZ);
        has_two  = (size_q >= TWO);
    end

`ifdef PARAM_STACK_ALU_EN
    logic [W-1:0] alu_res;

    // Two-operand result of S (below) and T (top), modulo 2^W.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = s_val + t_val;
            OP_SUB:  alu_res = s_val - t_val;
            OP_AND:  alu_res = s_val & t_val;
            OP_OR:   alu_res = s_val | t_val;
            OP_XOR:  alu_res = s_val ^ t_val;
            default: alu_res = '0;
        endcase
    end
`endif

    // Next-state decode: a rejected op leaves array and size untouched and
    // only drops valid; idle cycles keep everything including valid.
    always_comb begin
        mem_d   = mem_q;
        size_d  = size_q;
        valid_d = valid_q;
        if (apply) begin
            valid_d = 1'b0;
            case (op)
                OP_PUSH: if (!is_full) begin
                    mem_d[p_idx] = in;
                    size_d       = size_q + ONE;
                    valid_d      = 1'b1;
                end
                OP_POP: if (!is_empty) begin
                    size_d  = size_q - ONE;
                    valid_d = 1'b1;
                end
                OP_DUP: if (!is_empty && !is_full) begin
                    mem_d[p_idx] = t_val;
                    size_d       = size_q + ONE;
                    valid_d      = 1'b1;
                end
                OP_SWAP: if (has_two) begin
                    mem_d[t_idx] = s_val;
                    mem_d[s_idx] = t_val;
                    valid_d      = 1'b1;
                end
                OP_OVER: if (has_two && !is_full) begin
                    mem_d[p_idx] = s_val;
                    size_d       = size_q + ONE;
                    valid_d      = 1'b1;
                end
                OP_CLEAR: begin
                    size_d  = '0;
                    valid_d = 1'b1;
                end
`ifdef PARAM_STACK_ALU_EN
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: if (has_two) begin
                    mem_d[s_idx] = alu_res;
                    size_d       = size_q - ONE;
                    valid_d      = 1'b1;
                end
`endif
                default: valid_d = 1'b0;
            endcase
        end
    end

    // Control state: counter and last-op status, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q  <= '0;
            valid_q <= 1'b1;
        end else begin
            size_q  <= size_d;
            valid_q <= valid_d;
        end
    end

    // Storage array: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Output decode: head is a combinational read of the top entry.
    always_comb begin
        head  = is_empty ? '0 : t_val;
        empty = is_empty;
        full  = is_full;
        size  = size_q;
        valid = valid_q;
    end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at W=8, D=4: a vector table for the main
// opcode sequences plus hand-written sequences for ALU, fill/drain and reset.
module tb_param_stack;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SW = $clog2(D + 1);

    localparam logic [3:0] PUSH = 4'd0, POP = 4'd1, DUP = 4'd2, SWAP = 4'd3,
                           OVER = 4'd4, CLR = 4'd5, ADD = 4'd6, SUB = 4'd7,
                           AND_ = 4'd8, OR_ = 4'd9, XOR_ = 4'd10;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_s;
    logic [3:0]    op_s;
    logic          apply_s;
    logic [W-1:0]  head_s;
    logic          empty_s;
    logic          full_s;
    logic [SW-1:0] size_s;
    logic          valid_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          apply;
        logic [3:0]    op;
        logic [W-1:0]  in;
        logic [W-1:0]  e_head;
        logic          e_empty;
        logic          e_full;
        logic [SW-1:0] e_size;
        logic          e_valid;
    } vec_t;

    vec_t vecs[$];

    param_stack #(.W(W), .D(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_s),
        .op    (op_s),
        .apply (apply_s),
        .head  (head_s),
        .empty (empty_s),
        .full  (full_s),
        .size  (size_s),
        .valid (valid_s)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] h, input logic e,
                           input logic f, input logic [SW-1:0] s, input logic v);
        chk({tag, ".head"},  32'(head_s),  32'(h));
        chk({tag, ".empty"}, 32'(empty_s), 32'(e));
        chk({tag, ".full"},  32'(full_s),  32'(f));
        chk({tag, ".size"},  32'(size_s),  32'(s));
        chk({tag, ".valid"}, 32'(valid_s), 32'(v));
    endtask

    // Drive on the falling edge, sample 1 unit after the rising edge.
    task automatic step(input logic a, input logic [3:0] o, input logic [W-1:0] d);
        @(negedge clk);
        apply_s = a;
        op_s    = o;
        in_s    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic a, input logic [3:0] o, input logic [W-1:0] d,
                           input logic [W-1:0] h, input logic e, input logic f,
                           input logic [SW-1:0] s, input logic v);
        vec_t t;
        t.apply = a; t.op = o; t.in = d;
        t.e_head = h; t.e_empty = e; t.e_full = f; t.e_size = s; t.e_valid = v;
        vecs.push_back(t);
    endtask

    initial begin
        logic [W-1:0] model[$];

        rst = 1'b1; apply_s = 1'b0; op_s = '0; in_s = '0;

        //           apply op    in     head emp full size valid
        add_vec(1'b0, PUSH, 8'd99, 8'd0,  1, 0, 3'd0, 1);   // idle x3
        add_vec(1'b0, PUSH, 8'd99, 8'd0,  1, 0, 3'd0, 1);
        add_vec(1'b0, POP,  8'd0,  8'd0,  1, 0, 3'd0, 1);
        add_vec(1'b1, PUSH, 8'd22, 8'd22, 0, 0, 3'd1, 1);
        add_vec(1'b1, PUSH, 8'd7,  8'd7,  0, 0, 3'd2, 1);
        add_vec(1'b1, PUSH, 8'd9,  8'd9,  0, 0, 3'd3, 1);
        add_vec(1'b1, PUSH, 8'd4,  8'd4,  0, 1, 3'd4, 1);
        add_vec(1'b1, PUSH, 8'd1,  8'd4,  0, 1, 3'd4, 0);   // push at full
        add_vec(1'b1, DUP,  8'd0,  8'd4,  0, 1, 3'd4, 0);   // dup at full
        add_vec(1'b1, POP,  8'd0,  8'd9,  0, 0, 3'd3, 1);
        add_vec(1'b1, POP,  8'd0,  8'd7,  0, 0, 3'd2, 1);
        add_vec(1'b1, POP,  8'd0,  8'd22, 0, 0, 3'd1, 1);
        add_vec(1'b1, POP,  8'd0,  8'd0,  1, 0, 3'd0, 1);
        add_vec(1'b1, POP,  8'd0,  8'd0,  1, 0, 3'd0, 0);   // pop at empty
        add_vec(1'b1, SWAP, 8'd0,  8'd0,  1, 0, 3'd0, 0);
        add_vec(1'b1, PUSH, 8'd3,  8'd3,  0, 0, 3'd1, 1);
        add_vec(1'b1, SWAP, 8'd0,  8'd3,  0, 0, 3'd1, 0);   // swap with one entry
        add_vec(1'b1, OVER, 8'd0,  8'd3,  0, 0, 3'd1, 0);
        add_vec(1'b1, PUSH, 8'd5,  8'd5,  0, 0, 3'd2, 1);
        add_vec(1'b1, SWAP, 8'd0,  8'd3,  0, 0, 3'd2, 1);   // [5,3]
        add_vec(1'b1, OVER, 8'd0,  8'd5,  0, 0, 3'd3, 1);   // [5,3,5]
        add_vec(1'b1, DUP,  8'd0,  8'd5,  0, 1, 3'd4, 1);
        add_vec(1'b1, DUP,  8'd0,  8'd5,  0, 1, 3'd4, 0);
        add_vec(1'b0, CLR,  8'd0,  8'd5,  0, 1, 3'd4, 0);   // idle holds valid=0
        add_vec(1'b1, OVER, 8'd0,  8'd5,  0, 1, 3'd4, 0);   // over at full
        add_vec(1'b1, POP,  8'd0,  8'd5,  0, 0, 3'd3, 1);   // [5,3,5]
        add_vec(1'b1, POP,  8'd0,  8'd3,  0, 0, 3'd2, 1);
        add_vec(1'b1, CLR,  8'd0,  8'd0,  1, 0, 3'd0, 1);
        add_vec(1'b1, 4'd13, 8'd1, 8'd0,  1, 0, 3'd0, 0);   // reserved
        add_vec(1'b1, 4'd15, 8'd1, 8'd0,  1, 0, 3'd0, 0);
        add_vec(1'b1, PUSH, 8'd1,  8'd1,  0, 0, 3'd1, 1);
        add_vec(1'b1, 4'd11, 8'd2, 8'd1,  0, 0, 3'd1, 0);
        add_vec(1'b1, CLR,  8'd0,  8'd0,  1, 0, 3'd0, 1);

        // Reset phase
        repeat (2) @(posedge clk);
        #1;
        chk_all("in_reset", 8'd0, 1, 0, 3'd0, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].apply, vecs[i].op, vecs[i].in);
            chk_all($sformatf("vec%0d", i), vecs[i].e_head, vecs[i].e_empty,
                    vecs[i].e_full, vecs[i].e_size, vecs[i].e_valid);
        end

        // ALU sequences
        step(1'b1, PUSH, 8'd3);
        step(1'b1, PUSH, 8'd5);
        step(1'b1, SUB,  8'd0);
`ifdef PARAM_STACK_ALU_EN
        chk_all("alu_sub", 8'd254, 0, 0, 3'd1, 1);
        step(1'b1, ADD, 8'd0);
        chk_all("alu_add_one", 8'd254, 0, 0, 3'd1, 0);
        step(1'b1, PUSH, 8'd2);
        step(1'b1, ADD, 8'd0);
        chk_all("alu_add_wrap", 8'd0, 0, 0, 3'd1, 1);
        step(1'b1, CLR, 8'd0);
        step(1'b1, PUSH, 8'd1);
        step(1'b1, PUSH, 8'd2);
        step(1'b1, PUSH, 8'd3);
        step(1'b1, PUSH, 8'd4);
        step(1'b1, ADD, 8'd0);
        chk_all("alu_add_full", 8'd7, 0, 0, 3'd3, 1);
        step(1'b1, AND_, 8'd0);
        chk_all("alu_and", 8'd2, 0, 0, 3'd2, 1);
        step(1'b1, XOR_, 8'd0);
        chk_all("alu_xor", 8'd3, 0, 0, 3'd1, 1);
        step(1'b1, PUSH, 8'h50);
        step(1'b1, OR_, 8'd0);
        chk_all("alu_or", 8'h53, 0, 0, 3'd1, 1);
`else
        chk_all("noalu_sub", 8'd5, 0, 0, 3'd2, 0);
        step(1'b1, PUSH, 8'd9);
        chk_all("noalu_push", 8'd9, 0, 0, 3'd3, 1);
        step(1'b1, ADD, 8'd0);
        chk_all("noalu_add", 8'd9, 0, 0, 3'd3, 0);
        step(1'b1, AND_, 8'd0);
        chk_all("noalu_and", 8'd9, 0, 0, 3'd3, 0);
        step(1'b1, OR_, 8'd0);
        chk_all("noalu_or", 8'd9, 0, 0, 3'd3, 0);
        step(1'b1, XOR_, 8'd0);
        chk_all("noalu_xor", 8'd9, 0, 0, 3'd3, 0);
`endif
        step(1'b1, CLR, 8'd0);
        chk_all("clr2", 8'd0, 1, 0, 3'd0, 1);

        // Repeated fill/drain against a small queue model
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < D; k++) begin
                logic [W-1:0] d;
                d = W'(r * 40 + k * 7 + 1);
                model.push_back(d);
                step(1'b1, PUSH, d);
                chk_all($sformatf("fill%0d_%0d", r, k), model[$],
                        1'b0, (model.size() == D), SW'(model.size()), 1'b1);
            end
            for (int k = 0; k < D; k++) begin
                void'(model.pop_back());
                step(1'b1, POP, 8'd0);
                chk_all($sformatf("drain%0d_%0d", r, k),
                        (model.size() == 0) ? 8'd0 : model[$],
                        (model.size() == 0), 1'b0, SW'(model.size()), 1'b1);
            end
        end

        // Reset asserted during an applied PUSH
        step(1'b1, PUSH, 8'd11);
        step(1'b1, 4'd12, 8'd0);
        chk_all("pre_rst", 8'd11, 0, 0, 3'd1, 0);
        @(negedge clk);
        apply_s = 1'b1; op_s = PUSH; in_s = 8'd77;
        #2 rst = 1'b1;
        #1;
        chk_all("rst_async", 8'd0, 1, 0, 3'd0, 1);
        @(posedge clk);
        #1;
        chk_all("rst_held", 8'd0, 1, 0, 3'd0, 1);
        @(negedge clk);
        rst = 1'b0; apply_s = 1'b0;
        step(1'b1, PUSH, 8'd8);
        chk_all("post_rst", 8'd8, 0, 0, 3'd1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack engine with an opcode interface, the successor to the fixed-width single-op stack. It adds configurable depth, explicit `full`/`size` status, stack-manipulation opcodes and optional two-operand ALU opcodes. It sits behind a simple command port driven by a controller or testbench: one opcode per `apply` cycle, with the top of stack always visible on `head`.

## Interface
- `W`, 8: data width in bits, at least 2.
- `D`, 8: stack depth in entries, at least 2.
- `SW`, `$clog2(D+1)`: width of `size`. Derived; do not override.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  W  operand for PUSH.
- `op`  in  4  opcode, sampled when `apply`=1.
- `apply`  in  1  execute `op` on this rising edge.
- `head`  out  W  top-of-stack value; 0 when empty.
- `empty`  out  1  size==0.
- `full`  out  1  size==D.
- `size`  out  SW  current entry count, 0..D.
- `valid`  out  1  result of the last applied op: 1 if legal, 0 if rejected.

## Operation
- Storage: D×W register array plus `size` counter. `T` is the top entry, `S` is the entry below it.
- Opcodes and their legality conditions:
  - 0 PUSH: legal if size<D. Writes `in` as the new top; size+1.
  - 1 POP: legal if size≥1. size−1.
  - 2 DUP: legal if 1≤size<D. Pushes a copy of T.
  - 3 SWAP: legal if size≥2. Exchanges T and S.
  - 4 OVER: legal if size≥2 and size<D. Pushes a copy of S.
  - 5 CLEAR: always legal. size→0. Array contents are don't-care.
  - 6 ADD: result S+T.
  - 7 SUB: result S−T.
  - 8 AND, 9 OR, 10 XOR: bitwise result of S and T.
  - For opcodes 6–10: legal if size≥2. Both operands are popped and the result is pushed, so size−1.
  - 11–15: reserved, always illegal.
- Illegal op: stack, `size` and `head` are unchanged, and `valid` goes to 0.
- Legal op: stack is updated, and `valid` goes to 1.
- `valid` holds its value until the next applied op. Cycles with `apply`=0 change nothing.
- Arithmetic is modulo 2^W with no carry or borrow output. For example, SUB with S=3, T=5, W=8 gives 254.
- `head` is a combinational read of entry size−1, forced to 0 when empty. `empty` and `full` are decoded from `size`.
- Reset values: size=0, `head`=0, `empty`=1, `full`=0, `valid`=1. Array contents are not reset.

## Timing
- One op per clock. Throughput is 1, and `apply` may stay high for back-to-back ops.
- An op sampled at edge k has its effect on all outputs visible after edge k, before edge k+1. Latency is 1 edge.
- `in` and `op` must be stable around the edge when `apply`=1. They are ignored otherwise.
- No internal state machine. Behaviour depends only on `size` and `op`.
- Boundaries:
  - PUSH or DUP at full: rejected, `full` stays 1.
  - POP at empty: rejected, `head` stays 0.
  - Binary op with size==1: rejected, T is preserved.
  - ADD at full: legal, because it reduces size.
  - Filling to D and draining to 0 repeatedly leaves no residual state.
- `rst` asserted mid-sequence, including during an `apply` cycle, immediately forces the reset values. The in-flight op is lost. The first op after `rst` falls is sampled at the next rising edge.

## Configuration
- `PARAM_STACK_ALU_EN` defined: opcodes 6–10 behave as specified above.
- `PARAM_STACK_ALU_EN` undefined: opcodes 6–10 are treated as reserved (illegal, `valid`=0, no state change), and no ALU logic is synthesised.
- Opcodes 0–5 are identical in both builds.

## Test plan
All scenarios use W=8, D=4.
- Reset, then idle for 3 cycles with `apply`=0 -> `head`=0, `empty`=1, `full`=0, `size`=0, `valid`=1 throughout.
- PUSH 22, 7, 9, 4, then PUSH 1 -> `head` sequence 22, 7, 9, 4, 4; `full`=1 after the 4th push; 5th push gives `valid`=0 with `size` staying 4.
- From the stack [22,7,9,4], apply POP ×4, then POP -> `head` sequence 9, 7, 22, 0; `empty`=1; final POP gives `valid`=0 and `size`=0.
- PUSH 3, PUSH 5, SWAP, OVER -> `head` sequence 3, 5, 3, 5 with `size`=3. Then DUP -> `size`=4. Then DUP -> `valid`=0.
- With the ALU macro defined: PUSH 3, PUSH 5, SUB -> `head`=254, `size`=1. Then ADD -> `valid`=0, `head`=254. PUSH 2, ADD -> `head`=0 (wraps). Without the macro, the same SUB gives `valid`=0, `head`=5, `size`=2.
- Opcode 13 -> `valid`=0 with no change. Then PUSH 1 -> `valid`=1. Assert `rst` during an applied PUSH -> all outputs return to reset values before the next edge.
